sal_cmd_sched: RTL

Command scheduler directly downstream of the per-bank controllers. Each cycle it collects ACT/RD/WR/PRE/REF requests from all bank controllers and grants at most one. It enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW) and drives one registered DRAM command per cycle to the PHY-side command encoder. Bank-local timing (tRCD, tRP, tRAS, tRFC, tRTP, tWTP) is enforced by the bank controllers; this block neither checks nor re-checks it.

---
 rtl/sal_sched_pkg.sv | 30 +++
 rtl/sal_rr_arbiter.sv | 62 ++++++
 rtl/sal_cmd_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sal_sched_pkg.sv
// ============================================================================
// Module   : sal_sched_pkg
// Purpose  : Shared command encoding and sizing constants for the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sal_sched_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } cmd_t;

    localparam int c_TW_DEFAULT        = 4;
    localparam int c_NUM_BANKS_DEFAULT = 4;

    function automatic int ba_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_BA_W_DEFAULT = ba_width(c_NUM_BANKS_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/sal_rr_arbiter.sv
// ============================================================================
// Module   : sal_rr_arbiter
// Purpose  : One-hot bank arbiter; round robin when SAL_SCHED_RR_EN is
//            defined, lowest-index fixed priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sal_rr_arbiter #(
    parameter int N = 4
) (
`ifdef SAL_SCHED_RR_EN
    input  logic         clk,
    input  logic         advance,
`endif
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [N-1:0] w_gnt;

`ifdef SAL_SCHED_RR_EN
    localparam int c_PW = $clog2(N);

    logic [c_PW-1:0] r_ptr;
    logic [c_PW-1:0] w_ptr_nxt;
    logic [c_PW-1:0] w_idx;
    logic            w_found;

    // N is a power of two, so pointer arithmetic wraps naturally.
    always_comb begin
        w_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = r_ptr + c_PW'(k);
            if (!w_found && req[w_idx]) begin
                w_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_ptr_nxt    = w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    assign w_gnt = req & (~req + N'(1));
`endif

    assign gnt = rst ? '0 : w_gnt;

endmodule

`default_nettype wire

// File: rtl/sal_cmd_sched.sv
// ============================================================================
// Module   : sal_cmd_sched
// Purpose  : Single-grant DRAM command scheduler with inter-bank timing and a
//            registered command output. Build option: SAL_SCHED_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sal_cmd_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int RA_WIDTH  = 14,
    parameter int CA_WIDTH  = 10,
    parameter int TW        = c_TW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BANKS-1:0]          act_req,
    input  logic [NUM_BANKS-1:0]          rd_req,
    input  logic [NUM_BANKS-1:0]          wr_req,
    input  logic [NUM_BANKS-1:0]          pre_req,
    input  logic [NUM_BANKS-1:0]          ref_req,
    input  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i,
    output logic [NUM_BANKS-1:0]          act_gnt,
    output logic [NUM_BANKS-1:0]          rd_gnt,
    output logic [NUM_BANKS-1:0]          wr_gnt,
    output logic [NUM_BANKS-1:0]          pre_gnt,
    output logic [NUM_BANKS-1:0]          ref_gnt,
    input  logic [TW-1:0]                 t_rrd,
    input  logic [TW-1:0]                 t_ccd,
    input  logic [TW-1:0]                 t_wtr,
    input  logic [TW-1:0]                 t_rtw,
    output logic                          cmd_valid_o,
    output cmd_t                          cmd_o,
    output logic [ba_width(NUM_BANKS)-1:0] cmd_ba_o,
    output logic [RA_WIDTH-1:0]           cmd_addr_o
);

    localparam int c_BA_W = ba_width(NUM_BANKS);

    logic [TW-1:0] r_cnt_rrd, r_cnt_ccd, r_cnt_wtr, r_cnt_rtw;
    logic          w_rd_ok, w_wr_ok, w_act_ok;
    logic [NUM_BANKS-1:0] w_arb_req [4];
    logic [NUM_BANKS-1:0] w_arb_gnt [4];
    logic [3:0]           w_sel;
    logic [NUM_BANKS-1:0] w_any_gnt;
    logic                 w_any;
    logic [c_BA_W-1:0]    w_bank;
    cmd_t                 w_cmd;
    logic [RA_WIDTH-1:0]  w_addr;

    // A loaded count of t-1 makes the constraint met exactly t cycles later.
    function automatic logic [TW-1:0] f_load(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    assign w_rd_ok  = (r_cnt_ccd == '0) && (r_cnt_wtr == '0);
    assign w_wr_ok  = (r_cnt_ccd == '0) && (r_cnt_rtw == '0);
    assign w_act_ok = (r_cnt_rrd == '0);

    // Arbiter slots: 0 column, 1 ACT, 2 PRE, 3 REF (also the priority order).
    assign w_arb_req[0] = (rd_req & {NUM_BANKS{w_rd_ok}}) | (wr_req & {NUM_BANKS{w_wr_ok}});
    assign w_arb_req[1] = act_req & {NUM_BANKS{w_act_ok}};
    assign w_arb_req[2] = pre_req;
    assign w_arb_req[3] = ref_req;

    always_comb begin
        w_sel    = '0;
        w_sel[0] = |w_arb_req[0];
        w_sel[1] = !w_sel[0] && (|w_arb_req[1]);
        w_sel[2] = !(|w_sel[1:0]) && (|w_arb_req[2]);
        w_sel[3] = !(|w_sel[2:0]) && (|w_arb_req[3]);
    end

    for (genvar g = 0; g < 4; g++) begin : g_arb
        sal_rr_arbiter #(
            .N(NUM_BANKS)
        ) u_arb (
`ifdef SAL_SCHED_RR_EN
            .clk    (clk),
            .advance(w_sel[g]),
`endif
            .rst    (rst),
            .req    (w_arb_req[g]),
            .gnt    (w_arb_gnt[g])
        );
    end

    assign rd_gnt  = w_arb_gnt[0] & rd_req & {NUM_BANKS{w_sel[0] && w_rd_ok}};
    assign wr_gnt  = w_arb_gnt[0] & wr_req & {NUM_BANKS{w_sel[0] && w_wr_ok}};
    assign act_gnt = w_arb_gnt[1] & {NUM_BANKS{w_sel[1]}};
    assign pre_gnt = w_arb_gnt[2] & {NUM_BANKS{w_sel[2]}};
    assign ref_gnt = w_arb_gnt[3] & {NUM_BANKS{w_sel[3]}};

    assign w_any_gnt = act_gnt | rd_gnt | wr_gnt | pre_gnt | ref_gnt;
    assign w_any     = |w_any_gnt;

    always_comb begin
        w_bank = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (w_any_gnt[i]) begin
                w_bank = c_BA_W'(i);
            end
        end
    end

    always_comb begin
        w_cmd  = NOP;
        w_addr = '0;
        if (|rd_gnt || |wr_gnt) begin
            w_cmd                 = (|rd_gnt) ? RD : WR;
            w_addr[CA_WIDTH-1:0]  = ca_i[w_bank*CA_WIDTH +: CA_WIDTH];
        end else if (|act_gnt) begin
            w_cmd  = ACT;
            w_addr = ra_i[w_bank*RA_WIDTH +: RA_WIDTH];
        end else if (|pre_gnt) begin
            w_cmd = PRE;
        end else if (|ref_gnt) begin
            w_cmd = REF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_rrd <= '0;
            r_cnt_ccd <= '0;
            r_cnt_wtr <= '0;
            r_cnt_rtw <= '0;
        end else begin
            r_cnt_rrd <= (|act_gnt)            ? f_load(t_rrd) : f_dec(r_cnt_rrd);
            r_cnt_ccd <= (|rd_gnt || |wr_gnt)  ? f_load(t_ccd) : f_dec(r_cnt_ccd);
            r_cnt_wtr <= (|wr_gnt)             ? f_load(t_wtr) : f_dec(r_cnt_wtr);
            r_cnt_rtw <= (|rd_gnt)             ? f_load(t_rtw) : f_dec(r_cnt_rtw);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= NOP;
            cmd_ba_o    <= '0;
            cmd_addr_o  <= '0;
        end else begin
            cmd_valid_o <= w_any;
            cmd_o       <= w_cmd;
            if (w_any) begin
                cmd_ba_o   <= w_bank;
                cmd_addr_o <= w_addr;
            end
        end
    end

endmodule

`default_nettype wire
